// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC, drives the imem req/ack handshake, applies JAL/branch/JALR redirects.
// Optional misaligned-target trap is built when PC_SEQ_MISALIGN_TRAP_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        redir_valid,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_base,
  input  logic [19:0] redir_imm,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        misalign
);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    TRAP       = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    RESET_HOLD = 1'b0,
    FETCH      = 1'b1
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  logic [31:0] jal_off;
  logic [31:0] br_off;
  logic [31:0] i_off;
  logic [31:0] target;
  logic        redir_accept;
  logic        imem_req_c;
  logic        flush_c;
  logic        misalign_c;

`ifndef PC_SEQ_MISALIGN_TRAP_EN
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
`endif

  always_comb begin
    jal_off = {{11{redir_imm[19]}}, redir_imm, 1'b0};
    br_off  = {{19{redir_imm[11]}}, redir_imm[11:0], 1'b0};
    i_off   = {{20{redir_imm[11]}}, redir_imm[11:0]};
    case (redir_type)
      2'b01:   target = redir_base + jal_off;
      2'b10:   target = redir_base + br_off;
      2'b11:   target = (redir_base + i_off) & ~32'h1;
      default: target = redir_base;
    endcase
  end

  assign redir_accept = (state_q == FETCH) && redir_valid && (redir_type != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    imem_req_c = 1'b0;
    flush_c    = 1'b0;
    misalign_c = 1'b0;
    case (state_q)
      RESET_HOLD: state_d = FETCH;
      FETCH: begin
        imem_req_c = !stall;
        if (imem_ack && !stall) begin
          pc_out_d   = pc_q;
          pc_plus4_d = pc_q + 32'd4;
          pc_d       = pc_q + 32'd4;
        end
        // A redirect overrides the increment; the acked address is still captured in pc_out.
        if (redir_accept) begin
          flush_c = 1'b1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
          if (target[1:0] != 2'b00) begin
            misalign_c = 1'b1;
            pc_d       = TRAP_PC;
            state_d    = TRAP;
          end else begin
            pc_d = target;
          end
`else
          pc_d = {target[31:2], 2'b00};
`endif
        end
      end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      TRAP: begin
        pc_d    = TRAP_PC;
        state_d = FETCH;
      end
`endif
      default: state_d = RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_HOLD;
      pc_q       <= RESET_PC;
      pc_out_q   <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign imem_req  = imem_req_c;
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign pc_plus4  = pc_plus4_q;
  assign flush     = flush_c;
  assign misalign  = misalign_c;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the RV32 core fetch stage. Holds the PC and issues instruction-memory fetch requests over a req/ack handshake. Applies JAL, branch and JALR redirects by sign-extending their immediates internally: 20-bit J-offsets to 32 bits, and 12-bit B/I-offsets to 32 bits. Sits between decode/branch resolution and the instruction memory, and replaces the standalone PC register and next-PC mux.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned-target trap
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  back-pressure from decode; freezes sequential PC advance
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address; always equals the internal PC register
- imem_ack  input  1  fetch accepted/completed this cycle (valid only while imem_req=1)
- redir_valid  input  1  redirect request, single-cycle
- redir_type  input  2  01 JAL, 10 branch-taken, 11 JALR, 00 ignored
- redir_base  input  32  JAL/branch: PC of the jump instruction; JALR: rs1 value
- redir_imm  input  20  raw immediate; JAL uses [19:0], branch/JALR use [11:0]
- pc_out  output  32  address of the last accepted fetch
- pc_plus4  output  32  pc_out + 4 (link value)
- flush  output  1  squash the instruction in decode
- misalign  output  1  misaligned-target trap pulse

## Operation
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state RESET_HOLD, PC=RESET_PC, imem_req=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, flush=0, misalign=0.
- States:
  - RESET_HOLD: imem_req=0; unconditionally → FETCH next cycle.
  - FETCH: imem_req = !stall. On imem_ack && !stall: pc_out←PC, PC←PC+4.
  - TRAP: imem_req=0; PC=TRAP_PC; → FETCH next cycle.
- Target arithmetic is modulo 2^32:
  - JAL: redir_base + (sext20(imm[19:0]) << 1)
  - Branch: redir_base + (sext12(imm[11:0]) << 1)
  - JALR: (redir_base + sext12(imm[11:0])) & ~32'h1
- Sign extension copies bit 19 (JAL) or bit 11 (branch/JALR) into all upper bits.
- Redirect acceptance:
  - Accepted only in FETCH. Ignored in RESET_HOLD and TRAP, and ignored when redir_type=00.
  - Accepted redirect: PC←target, flush=1 combinationally in the same cycle.
- Priority: redirect > imem_ack increment > stall hold. If a redirect and imem_ack coincide, pc_out still captures the acked address, but that instruction is squashed by flush and the PC takes the target, not PC+4.
- A redirect during stall is accepted; the PC takes the target.
- Misalignment: target[1:0]≠00 → misalign=1, PC←TRAP_PC, state→TRAP (see Configuration).
- Wrap-around: PC=32'hFFFF_FFFC advances to 32'h0000_0000; no flag is raised.
- Reset asserted mid-fetch: all state returns immediately to the reset values. An outstanding ack is dropped.

## Timing
- PC update latency is 1 cycle. imem_addr shows the redirect target on the cycle after redir_valid.
- flush and misalign are combinational, high only in the acceptance cycle.
- pc_out and pc_plus4 are registered, updated on the edge following imem_ack.
- Sustained throughput: one fetch per cycle with imem_ack tied high and stall=0.
- Redirect-to-first-target-request: 1 cycle. Misaligned redirect to first TRAP_PC request: 2 cycles (through TRAP).

## Configuration
- PC_SEQ_MISALIGN_TRAP_EN defined: misaligned targets raise misalign, load TRAP_PC and enter TRAP.
- Not defined:
  - target[1:0] is forced to 00.
  - misalign is tied to 0.
  - The TRAP state is not built.
  - TRAP_PC is unused.

## Test plan
- Reset release with imem_ack=1, stall=0: imem_addr sequence 0x0, 0x4, 0x8, 0xC; imem_req low for exactly the first cycle; pc_plus4 tracks pc_out+4.
- JAL with redir_base=0x100, imm=20'hFFFFE (−2 → −4 bytes): imem_addr=0x0FC next cycle, flush=1 one cycle. With imm=20'h00010: imem_addr=0x120.
- Branch with redir_base=0x200, imm[11:0]=12'h800: target 0x200−0x1000 = 0xFFFF_F200. JALR with base=0x1001, imm=0: target 0x1000.
- Misaligned JALR with base=0x102, imm=0, macro defined: misalign=1, TRAP cycle with imem_req=0, then imem_addr=0x100. Macro undefined: imem_addr=0x100 and misalign stays 0.
- stall=1 for 3 cycles with imem_ack=1: PC and pc_out constant, imem_req=0. A redirect to 0x40 during the stall gives imem_addr=0x40 next cycle.
- Wrap and async reset: force PC to 0xFFFF_FFFC with ack, giving next address 0x0. Assert rst_n low mid-cycle: outputs reach the reset values without waiting for a clk edge.
